// File: rtl/rpn_operand_stack.sv
// ---------------------------------------------------------------------------
// rpn_operand_stack
//
// Parametrised operand stack for the RPN ALU. It sits between the debounced
// keypad/switch front end and the ALU operand inputs. It supports push, pop,
// swap-top (push and pop together) and reduce (pop two, push the ALU result).
// It also tracks occupancy, raises full/empty flags, emits one-cycle error
// pulses for rejected or illegal commands, and emits an exec_pulse when a push
// brings the occupancy to EXEC_COUNT.
//
// Parameters
//   WIDTH       bits per operand
//   DEPTH       number of entries (>= 2)
//   EXEC_COUNT  occupancy that fires exec_pulse on a push (1..DEPTH)
//   OVF_SHIFT   0: push when full is rejected; 1: bottom entry is discarded
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   push_en        push data_in onto the top
//   pop_en         remove the top entry
//   reduce_en      replace the top two entries with result_in
//   data_in        operand to push
//   result_in      ALU result used by reduce
//   stack_flat     entry i at [i*WIDTH +: WIDTH], entry 0 is the top
//   count          number of valid entries, 0..DEPTH
//   empty          count == 0
//   full           count == DEPTH
//   exec_pulse     one-cycle pulse after a push that reaches EXEC_COUNT
//   overflow_err   one-cycle pulse on a rejected push
//   underflow_err  one-cycle pulse on an illegal pop or reduce
// ---------------------------------------------------------------------------
module rpn_operand_stack #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 3,
  parameter int EXEC_COUNT = 3,
  parameter bit OVF_SHIFT  = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_en,
  input  logic                         pop_en,
  input  logic                         reduce_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [WIDTH-1:0]             result_in,
  output logic [WIDTH*DEPTH-1:0]       stack_flat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         exec_pulse,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] EXEC_C  = CW'(EXEC_COUNT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP,
    OP_REDUCE
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [CW-1:0]    count_d;
  logic             exec_d;
  logic             ovf_d;
  logic             udf_d;

  // Resolve the simultaneous strobes into one operation. Push together with
  // pop on an empty stack has nothing to swap, so it degrades to a plain push.
  always_comb begin
    op = OP_IDLE;
    if (reduce_en) begin
      op = OP_REDUCE;
    end else if (push_en && pop_en) begin
      op = (count == '0) ? OP_PUSH : OP_SWAP;
    end else if (pop_en) begin
      op = OP_POP;
    end else if (push_en) begin
      op = OP_PUSH;
    end
  end

  // Next-state computation. Every shift that vacates the bottom slot loads a
  // zero there, so slots at or beyond count always read 0. A reduce consumes
  // the top two operands and pushes one result. The result therefore sits
  // directly above what used to be the third entry.
  always_comb begin
    entry_d = entry_q;
    count_d = count;
    exec_d  = 1'b0;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (count != DEPTH_C || OVF_SHIFT) begin
          entry_d[0] = data_in;
          for (int i = 1; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i-1];
          end
          if (count != DEPTH_C) begin
            count_d = count + ONE_C;
          end
          exec_d = (count_d == EXEC_C);
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_POP: begin
        if (count != '0) begin
          for (int i = 0; i < DEPTH-1; i++) begin
            entry_d[i] = entry_q[i+1];
          end
          entry_d[DEPTH-1] = '0;
          count_d = count - ONE_C;
        end else begin
          udf_d = 1'b1;
        end
      end
      OP_SWAP: begin
        entry_d[0] = data_in;
      end
      OP_REDUCE: begin
        if (count >= TWO_C) begin
          entry_d[0] = result_in;
          for (int i = 1; i < DEPTH-1; i++) begin
            entry_d[i] = entry_q[i+1];
          end
          entry_d[DEPTH-1] = '0;
          count_d = count - ONE_C;
        end else begin
          udf_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // State and registered outputs. Flags are derived from the next count so
  // they line up with the count they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      count         <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      exec_pulse    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      entry_q       <= entry_d;
      count         <= count_d;
      empty         <= (count_d == '0);
      full          <= (count_d == DEPTH_C);
      exec_pulse    <= exec_d;
      overflow_err  <= ovf_d;
      underflow_err <= udf_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stack_flat[g*WIDTH +: WIDTH] = entry_q[g];
  end

endmodule

// File: tb/tb_rpn_operand_stack.sv
// ---------------------------------------------------------------------------
// tb_rpn_operand_stack
//
// Drives three stack configurations with one shared command stream:
//   dut_a : WIDTH=8,  DEPTH=3, EXEC_COUNT=3, OVF_SHIFT=0
//   dut_b : WIDTH=8,  DEPTH=3, EXEC_COUNT=3, OVF_SHIFT=1
//   dut_c : WIDTH=16, DEPTH=5, EXEC_COUNT=2, OVF_SHIFT=0
// Each configuration has a list-based reference model (top of stack at queue
// index 0). The bench compares the model with every output after every cycle.
// Hand-computed constants cover the directed scenarios.
// ---------------------------------------------------------------------------
module tb_rpn_operand_stack;

  logic        clk;
  logic        reset;
  logic        push_en;
  logic        pop_en;
  logic        reduce_en;
  logic [15:0] data_in;
  logic [15:0] result_in;

  logic [23:0] a_flat;
  logic [1:0]  a_count;
  logic        a_empty, a_full, a_exec, a_ovf, a_udf;
  logic [23:0] b_flat;
  logic [1:0]  b_count;
  logic        b_empty, b_full, b_exec, b_ovf, b_udf;
  logic [79:0] c_flat;
  logic [2:0]  c_count;
  logic        c_empty, c_full, c_exec, c_ovf, c_udf;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  bit          m_exec [3];
  bit          m_ovf  [3];
  bit          m_udf  [3];

  rpn_operand_stack #(.WIDTH(8), .DEPTH(3), .EXEC_COUNT(3), .OVF_SHIFT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .push_en(push_en), .pop_en(pop_en), .reduce_en(reduce_en),
    .data_in(data_in[7:0]), .result_in(result_in[7:0]), .stack_flat(a_flat), .count(a_count),
    .empty(a_empty), .full(a_full), .exec_pulse(a_exec), .overflow_err(a_ovf),
    .underflow_err(a_udf)
  );

  rpn_operand_stack #(.WIDTH(8), .DEPTH(3), .EXEC_COUNT(3), .OVF_SHIFT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .push_en(push_en), .pop_en(pop_en), .reduce_en(reduce_en),
    .data_in(data_in[7:0]), .result_in(result_in[7:0]), .stack_flat(b_flat), .count(b_count),
    .empty(b_empty), .full(b_full), .exec_pulse(b_exec), .overflow_err(b_ovf),
    .underflow_err(b_udf)
  );

  rpn_operand_stack #(.WIDTH(16), .DEPTH(5), .EXEC_COUNT(2), .OVF_SHIFT(1'b0)) dut_c (
    .clk(clk), .reset(reset), .push_en(push_en), .pop_en(pop_en), .reduce_en(reduce_en),
    .data_in(data_in), .result_in(result_in), .stack_flat(c_flat), .count(c_count),
    .empty(c_empty), .full(c_full), .exec_pulse(c_exec), .overflow_err(c_ovf),
    .underflow_err(c_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model step for configuration k, written as list operations.
  task automatic modelStep(input int k, input bit p, input bit po, input bit r,
                           input logic [15:0] d, input logic [15:0] res);
    logic [15:0] w[$];
    logic [15:0] dm;
    logic [15:0] rm;
    int dep;
    int ec;
    bit sh;
    case (k)
      0: w = q0;
      1: w = q1;
      default: w = q2;
    endcase
    dep = (k == 2) ? 5 : 3;
    ec  = (k == 2) ? 2 : 3;
    sh  = (k == 1);
    dm  = (k == 2) ? d   : {8'h00, d[7:0]};
    rm  = (k == 2) ? res : {8'h00, res[7:0]};
    m_exec[k] = 1'b0;
    m_ovf[k]  = 1'b0;
    m_udf[k]  = 1'b0;
    if (r) begin
      if (w.size() >= 2) begin
        void'(w.pop_front());
        void'(w.pop_front());
        w.push_front(rm);
      end else begin
        m_udf[k] = 1'b1;
      end
    end else if (p && po && w.size() > 0) begin
      w[0] = dm;
    end else if (po && !p) begin
      if (w.size() > 0) void'(w.pop_front());
      else m_udf[k] = 1'b1;
    end else if (p) begin
      if (w.size() < dep) begin
        w.push_front(dm);
        m_exec[k] = (w.size() == ec);
      end else if (sh) begin
        w.push_front(dm);
        void'(w.pop_back());
        m_exec[k] = (dep == ec);
      end else begin
        m_ovf[k] = 1'b1;
      end
    end
    case (k)
      0: q0 = w;
      1: q1 = w;
      default: q2 = w;
    endcase
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) begin
      m_exec[k] = 1'b0;
      m_ovf[k]  = 1'b0;
      m_udf[k]  = 1'b0;
    end
  endtask

  // Compares one configuration's outputs against its model.
  task automatic checkModel(input int k, input string nm, input logic [79:0] flat,
                            input logic [2:0] cnt, input bit emp, input bit fl,
                            input bit ex, input bit ov, input bit un);
    logic [15:0] w[$];
    logic [79:0] ef;
    int wid;
    int dep;
    case (k)
      0: w = q0;
      1: w = q1;
      default: w = q2;
    endcase
    wid = (k == 2) ? 16 : 8;
    dep = (k == 2) ? 5 : 3;
    ef  = '0;
    for (int i = 0; i < w.size(); i++) begin
      ef = ef | (80'(w[i]) << (i * wid));
    end
    checkOutput($sformatf("%s_flat", nm), flat, ef);
    checkOutput($sformatf("%s_count", nm), 80'(cnt), 80'(w.size()));
    checkOutput($sformatf("%s_empty", nm), 80'(emp), 80'(w.size() == 0));
    checkOutput($sformatf("%s_full", nm), 80'(fl), 80'(w.size() == dep));
    checkOutput($sformatf("%s_exec", nm), 80'(ex), 80'(m_exec[k]));
    checkOutput($sformatf("%s_ovf", nm), 80'(ov), 80'(m_ovf[k]));
    checkOutput($sformatf("%s_udf", nm), 80'(un), 80'(m_udf[k]));
  endtask

  task automatic checkAll();
    checkModel(0, "a", 80'(a_flat), 3'(a_count), a_empty, a_full, a_exec, a_ovf, a_udf);
    checkModel(1, "b", 80'(b_flat), 3'(b_count), b_empty, b_full, b_exec, b_ovf, b_udf);
    checkModel(2, "c", c_flat, c_count, c_empty, c_full, c_exec, c_ovf, c_udf);
  endtask

  // Presents one command for one clock, steps the models at the edge, then
  // checks all outputs 1 time unit after the edge.
  task automatic applyStimulus(input bit p, input bit po, input bit r,
                               input logic [15:0] d, input logic [15:0] res);
    push_en   = p;
    pop_en    = po;
    reduce_en = r;
    data_in   = d;
    result_in = res;
    @(posedge clk);
    for (int k = 0; k < 3; k++) modelStep(k, p, po, r, d, res);
    #1;
    push_en   = 1'b0;
    pop_en    = 1'b0;
    reduce_en = 1'b0;
    checkAll();
  endtask

  initial begin
    int sel;
    reset     = 1'b1;
    push_en   = 1'b0;
    pop_en    = 1'b0;
    reduce_en = 1'b0;
    data_in   = '0;
    result_in = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_a_empty", 80'(a_empty), 80'(1));
    checkOutput("rst_a_count", 80'(a_count), 80'(0));
    checkAll();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] push three operands");
    applyStimulus(1, 0, 0, 16'h0011, 16'h0);
    applyStimulus(1, 0, 0, 16'h0022, 16'h0);
    checkOutput("t1_a_exec_early", 80'(a_exec), 80'(0));
    applyStimulus(1, 0, 0, 16'h0033, 16'h0);
    checkOutput("t1_a_flat", 80'(a_flat), 80'h112233);
    checkOutput("t1_a_count", 80'(a_count), 80'(3));
    checkOutput("t1_a_full", 80'(a_full), 80'(1));
    checkOutput("t1_a_exec", 80'(a_exec), 80'(1));
    applyStimulus(0, 0, 0, 16'h0, 16'h0);
    checkOutput("t1_a_exec_gone", 80'(a_exec), 80'(0));

    $display("[TB] push when full");
    applyStimulus(1, 0, 0, 16'h0044, 16'h0);
    checkOutput("t2_a_flat", 80'(a_flat), 80'h112233);
    checkOutput("t2_a_ovf", 80'(a_ovf), 80'(1));
    checkOutput("t2_b_flat", 80'(b_flat), 80'h223344);
    checkOutput("t2_b_count", 80'(b_count), 80'(3));
    checkOutput("t2_b_exec", 80'(b_exec), 80'(1));
    checkOutput("t2_b_ovf", 80'(b_ovf), 80'(0));
    applyStimulus(0, 0, 0, 16'h0, 16'h0);
    checkOutput("t2_a_ovf_gone", 80'(a_ovf), 80'(0));

    $display("[TB] reduce");
    applyStimulus(0, 0, 1, 16'h0, 16'h0055);
    checkOutput("t3_a_flat1", 80'(a_flat), 80'h001155);
    checkOutput("t3_a_count1", 80'(a_count), 80'(2));
    applyStimulus(0, 0, 1, 16'h0, 16'h0066);
    checkOutput("t3_a_flat2", 80'(a_flat), 80'h000066);
    checkOutput("t3_a_count2", 80'(a_count), 80'(1));
    applyStimulus(0, 0, 1, 16'h0, 16'h0077);
    checkOutput("t3_a_flat3", 80'(a_flat), 80'h000066);
    checkOutput("t3_a_udf", 80'(a_udf), 80'(1));

    $display("[TB] pop on empty and swap-top");
    applyStimulus(0, 1, 0, 16'h0, 16'h0);
    applyStimulus(0, 1, 0, 16'h0, 16'h0);
    checkOutput("t4_a_udf", 80'(a_udf), 80'(1));
    checkOutput("t4_a_count0", 80'(a_count), 80'(0));
    applyStimulus(1, 1, 0, 16'h000A, 16'h0);
    checkOutput("t4_a_flat1", 80'(a_flat), 80'h00000A);
    checkOutput("t4_a_count1", 80'(a_count), 80'(1));
    applyStimulus(1, 1, 0, 16'h000B, 16'h0);
    checkOutput("t4_a_flat2", 80'(a_flat), 80'h00000B);
    checkOutput("t4_a_count2", 80'(a_count), 80'(1));

    $display("[TB] asynchronous reset");
    applyStimulus(1, 0, 0, 16'h0001, 16'h0);
    checkOutput("t5_a_count_pre", 80'(a_count), 80'(2));
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("t5_a_count_async", 80'(a_count), 80'(0));
    checkOutput("t5_a_flat_async", 80'(a_flat), 80'h0);
    checkOutput("t5_a_empty_async", 80'(a_empty), 80'(1));
    checkOutput("t5_c_flat_async", c_flat, 80'h0);
    checkAll();
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkAll();
    applyStimulus(1, 0, 0, 16'h000C, 16'h0);
    checkOutput("t5_a_count_post", 80'(a_count), 80'(1));
    checkOutput("t5_a_flat_post", 80'(a_flat), 80'h00000C);
    checkOutput("t5_a_exec_post", 80'(a_exec), 80'(0));

    $display("[TB] random command stream");
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40)      applyStimulus(1, 0, 0, 16'($urandom), 16'($urandom));
      else if (sel < 60) applyStimulus(0, 1, 0, 16'($urandom), 16'($urandom));
      else if (sel < 75) applyStimulus(0, 0, 1, 16'($urandom), 16'($urandom));
      else if (sel < 85) applyStimulus(1, 1, 0, 16'($urandom), 16'($urandom));
      else if (sel < 92) applyStimulus(1, 1, 1, 16'($urandom), 16'($urandom));
      else               applyStimulus(0, 0, 0, 16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
